mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data; round-robin on ties, one access per MEM_LAT+2 cycles.
// Requests are sampled only while idle; requesters hold req until their one-cycle ack (ack rises MEM_LAT+1 cycles after sampling).
module mem_port_arbiter #(
   parameter int AW      = 64,
   parameter int DW      = 64,
   parameter int MEM_LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          owner
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          owner_q, owner_d;
   logic          last_grant_q, last_grant_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          grant_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      grant_data   = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_we       = 1'b0;
      if_ack       = 1'b0;
      d_ack        = 1'b0;

      case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               // On a tie the port that lost last time wins.
               grant_data   = d_req && (!if_req || !last_grant_q);
               state_d      = ACCESS;
               owner_d      = grant_data;
               last_grant_d = grant_data;
               cnt_d        = CNT_INIT;
               addr_d       = grant_data ? d_addr : if_addr;
               wdata_d      = grant_data ? d_wdata : '0;
               we_d         = grant_data && d_we;
            end
         end
         ACCESS: begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            // The counter only counts down, so its initial value marks the first cycle.
            mem_we    = we_q && (cnt_q == CNT_INIT);
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = RESP;
               if (!we_q) begin
                  if (owner_q) d_rdata_d = mem_rdata;
                  else         if_rdata_d = mem_rdata;
               end
            end
         end
         RESP: begin
            if_ack  = !owner_q;
            d_ack   = owner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q != IDLE);
   assign owner    = owner_q;
   assign if_rdata = if_rdata_q;
   assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three builds (MEM_LAT 2, 1, 15) sharing clock and reset,
// directed scenarios plus random traffic against a cycle-numbered transaction model.
module tb_mem_port_arbiter;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int NI = 3;

   typedef struct packed {
      int            ack_n;
      int            we_cnt;
      int            we_n;
      logic [AW-1:0] we_addr;
      logic [DW-1:0] we_data;
      logic          other_ack;
      logic          ack_after;
      logic          busy_after;
   } obs_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          if_req    [NI];
   logic [AW-1:0] if_addr   [NI];
   logic [DW-1:0] if_rdata  [NI];
   logic          if_ack    [NI];
   logic          d_req     [NI];
   logic          d_we      [NI];
   logic [AW-1:0] d_addr    [NI];
   logic [DW-1:0] d_wdata   [NI];
   logic [DW-1:0] d_rdata   [NI];
   logic          d_ack     [NI];
   logic [AW-1:0] mem_addr  [NI];
   logic [DW-1:0] mem_wdata [NI];
   logic          mem_we    [NI];
   logic [DW-1:0] mem_rdata [NI];
   logic          busy      [NI];
   logic          owner     [NI];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mem_port_arbiter #(
         .AW(AW), .DW(DW), .MEM_LAT(g == 0 ? 2 : (g == 1 ? 1 : 15))
      ) u_dut (
         .clk(clk), .reset(reset),
         .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ack(if_ack[g]),
         .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
         .d_rdata(d_rdata[g]), .d_ack(d_ack[g]),
         .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_we(mem_we[g]),
         .mem_rdata(mem_rdata[g]), .busy(busy[g]), .owner(owner[g])
      );
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
   endfunction

   // Drives one request on an idle arbiter and records what the memory side and acks did.
   // Cycle 0 is the idle cycle in which the request is first presented.
   task automatic one_access(input int k, input bit port, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                             input int drop_at, output obs_t o);
      o = '0;
      o.ack_n = -1;
      @(negedge clk);
      mem_rdata[k] = rdata;
      if (port) begin
         d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
      end else begin
         if_req[k] = 1'b1; if_addr[k] = addr;
      end
      for (int n = 1; n <= 40 && o.ack_n < 0; n++) begin
         @(negedge clk);
         if (mem_we[k]) begin
            o.we_cnt++; o.we_n = n; o.we_addr = mem_addr[k]; o.we_data = mem_wdata[k];
         end
         if (port ? if_ack[k] : d_ack[k]) o.other_ack = 1'b1;
         if (n == drop_at) begin if_req[k] = 1'b0; d_req[k] = 1'b0; end
         if (port ? d_ack[k] : if_ack[k]) begin
            o.ack_n = n; if_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
         end
      end
      @(negedge clk);
      o.ack_after  = if_ack[k] | d_ack[k];
      o.busy_after = busy[k];
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy[k]); end
         checks++; if (if_ack[k] !== 1'b0) begin errors++; $display("FAIL reset_if_ack[%0d]: got %b expected 0", k, if_ack[k]); end
         checks++; if (d_ack[k] !== 1'b0) begin errors++; $display("FAIL reset_d_ack[%0d]: got %b expected 0", k, d_ack[k]); end
         checks++; if (mem_we[k] !== 1'b0) begin errors++; $display("FAIL reset_mem_we[%0d]: got %b expected 0", k, mem_we[k]); end
         checks++; if (owner[k] !== 1'b0) begin errors++; $display("FAIL reset_owner[%0d]: got %b expected 0", k, owner[k]); end
         checks++; if (if_rdata[k] !== '0) begin errors++; $display("FAIL reset_if_rdata[%0d]: got %0h expected 0", k, if_rdata[k]); end
         checks++; if (d_rdata[k] !== '0) begin errors++; $display("FAIL reset_d_rdata[%0d]: got %0h expected 0", k, d_rdata[k]); end
         checks++; if (mem_addr[k] !== '0) begin errors++; $display("FAIL reset_mem_addr[%0d]: got %0h expected 0", k, mem_addr[k]); end
      end
      reset = 1'b0;
   endtask

   task automatic test_fetch();
      obs_t o;
      one_access(0, 1'b0, 1'b0, 64'h40, '0, 64'h0050_0093, -1, o);
      checks++; if (o.ack_n !== 3) begin errors++; $display("FAIL fetch_ack_latency: got %0d expected 3", o.ack_n); end
      checks++; if (if_rdata[0] !== 64'h0050_0093) begin errors++; $display("FAIL fetch_rdata: got %0h expected 500093", if_rdata[0]); end
      checks++; if (o.we_cnt !== 0) begin errors++; $display("FAIL fetch_mem_we: got %0d strobes expected 0", o.we_cnt); end
      checks++; if (o.other_ack !== 1'b0) begin errors++; $display("FAIL fetch_d_ack: got %b expected 0", o.other_ack); end
      checks++; if (o.ack_after !== 1'b0) begin errors++; $display("FAIL fetch_ack_width: got %b expected 0", o.ack_after); end
      checks++; if (o.busy_after !== 1'b0) begin errors++; $display("FAIL fetch_idle_after: got %b expected 0", o.busy_after); end
      checks++; if (owner[0] !== 1'b0) begin errors++; $display("FAIL fetch_owner: got %b expected 0", owner[0]); end
   endtask

   task automatic test_load();
      obs_t o;
      one_access(0, 1'b1, 1'b0, 64'h80, '0, 64'h1234_5678_9ABC_DEF0, -1, o);
      checks++; if (o.ack_n !== 3) begin errors++; $display("FAIL load_ack_latency: got %0d expected 3", o.ack_n); end
      checks++; if (d_rdata[0] !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL load_rdata: got %0h expected 123456789abcdef0", d_rdata[0]); end
      checks++; if (if_rdata[0] !== 64'h0050_0093) begin errors++; $display("FAIL load_if_rdata_kept: got %0h expected 500093", if_rdata[0]); end
      checks++; if (o.other_ack !== 1'b0) begin errors++; $display("FAIL load_if_ack: got %b expected 0", o.other_ack); end
      checks++; if (owner[0] !== 1'b1) begin errors++; $display("FAIL load_owner: got %b expected 1", owner[0]); end
   endtask

   task automatic test_store();
      obs_t o;
      one_access(0, 1'b1, 1'b1, 64'h100, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFF, -1, o);
      checks++; if (o.we_cnt !== 1) begin errors++; $display("FAIL store_we_count: got %0d expected 1", o.we_cnt); end
      checks++; if (o.we_n !== 1) begin errors++; $display("FAIL store_we_cycle: got %0d expected 1", o.we_n); end
      checks++; if (o.we_addr !== 64'h100) begin errors++; $display("FAIL store_mem_addr: got %0h expected 100", o.we_addr); end
      checks++; if (o.we_data !== 64'hDEAD) begin errors++; $display("FAIL store_mem_wdata: got %0h expected dead", o.we_data); end
      checks++; if (o.ack_n !== 3) begin errors++; $display("FAIL store_ack_latency: got %0d expected 3", o.ack_n); end
      checks++; if (d_rdata[0] !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL store_d_rdata_kept: got %0h expected 123456789abcdef0", d_rdata[0]); end
      checks++; if (if_rdata[0] !== 64'h0050_0093) begin errors++; $display("FAIL store_if_rdata_kept: got %0h expected 500093", if_rdata[0]); end
   endtask

   // Request withdrawn in the first access cycle must still complete on the short and long builds.
   task automatic test_latency();
      obs_t o;
      for (int k = 1; k < NI; k++) begin
         one_access(k, 1'b1, 1'b0, 64'h300 + 64'(k), '0, 64'hA5A5_0000 + 64'(k), 1, o);
         checks++; if (o.ack_n !== lat_of(k) + 1) begin errors++; $display("FAIL lat%0d_ack_latency: got %0d expected %0d", lat_of(k), o.ack_n, lat_of(k) + 1); end
         checks++; if (d_rdata[k] !== 64'hA5A5_0000 + 64'(k)) begin errors++; $display("FAIL lat%0d_rdata: got %0h expected %0h", lat_of(k), d_rdata[k], 64'hA5A5_0000 + 64'(k)); end
         checks++; if (if_rdata[k] !== '0) begin errors++; $display("FAIL lat%0d_if_rdata_kept: got %0h expected 0", lat_of(k), if_rdata[k]); end
         checks++; if (o.busy_after !== 1'b0) begin errors++; $display("FAIL lat%0d_idle_after: got %b expected 0", lat_of(k), o.busy_after); end
      end
   endtask

   task automatic test_tie();
      int ack_port [8];
      int ack_cyc  [8];
      int na = 0;
      bit simul = 1'b0;
      for (int i = 0; i < 8; i++) begin ack_port[i] = -1; ack_cyc[i] = -1; end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mem_rdata[0] = 64'hCAFE_F00D;
      if_req[0] = 1'b1; if_addr[0] = 64'h1000;
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 64'h2000;
      for (int n = 1; n <= 24; n++) begin
         @(negedge clk);
         if (if_ack[0] && d_ack[0]) simul = 1'b1;
         if ((if_ack[0] || d_ack[0]) && na < 8) begin
            ack_port[na] = d_ack[0] ? 1 : 0; ack_cyc[na] = n; na++;
         end
      end
      if_req[0] = 1'b0; d_req[0] = 1'b0;
      checks++; if (simul !== 1'b0) begin errors++; $display("FAIL tie_simultaneous_ack: got %b expected 0", simul); end
      checks++; if (na !== 6) begin errors++; $display("FAIL tie_ack_count: got %0d expected 6", na); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (ack_port[i] !== i % 2) begin errors++; $display("FAIL tie_order[%0d]: got port %0d expected %0d", i, ack_port[i], i % 2); end
         checks++; if (ack_cyc[i] !== 3 + 4 * i) begin errors++; $display("FAIL tie_spacing[%0d]: got cycle %0d expected %0d", i, ack_cyc[i], 3 + 4 * i); end
      end
   endtask

   task automatic test_reset_mid();
      bit saw_ack = 1'b0;
      int first_port = -1;
      int first_n = -1;
      @(negedge clk);
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 64'h200; mem_rdata[0] = 64'hBAD0_BAD0;
      repeat (2) @(negedge clk);
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b expected 1", busy[0]); end
      #1 reset = 1'b1;
      #1;
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy[0]); end
      checks++; if (d_ack[0] !== 1'b0) begin errors++; $display("FAIL rmid_d_ack: got %b expected 0", d_ack[0]); end
      checks++; if (if_ack[0] !== 1'b0) begin errors++; $display("FAIL rmid_if_ack: got %b expected 0", if_ack[0]); end
      checks++; if (mem_we[0] !== 1'b0) begin errors++; $display("FAIL rmid_mem_we: got %b expected 0", mem_we[0]); end
      checks++; if (mem_addr[0] !== '0) begin errors++; $display("FAIL rmid_mem_addr: got %0h expected 0", mem_addr[0]); end
      checks++; if (owner[0] !== 1'b0) begin errors++; $display("FAIL rmid_owner: got %b expected 0", owner[0]); end
      checks++; if (d_rdata[0] !== '0) begin errors++; $display("FAIL rmid_d_rdata: got %0h expected 0", d_rdata[0]); end
      checks++; if (if_rdata[0] !== '0) begin errors++; $display("FAIL rmid_if_rdata: got %0h expected 0", if_rdata[0]); end
      d_req[0] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (d_ack[0] || if_ack[0]) saw_ack = 1'b1;
      end
      checks++; if (saw_ack !== 1'b0) begin errors++; $display("FAIL rmid_no_ack: got %b expected 0", saw_ack); end
      if_req[0] = 1'b1; if_addr[0] = 64'h10;
      d_req[0] = 1'b1; d_addr[0] = 64'h20;
      for (int n = 1; n <= 10 && first_n < 0; n++) begin
         @(negedge clk);
         if (if_ack[0] || d_ack[0]) begin first_port = d_ack[0] ? 1 : 0; first_n = n; end
      end
      if_req[0] = 1'b0; d_req[0] = 1'b0;
      checks++; if (first_port !== 0) begin errors++; $display("FAIL rmid_tie_winner: got port %0d expected 0", first_port); end
      checks++; if (first_n !== 3) begin errors++; $display("FAIL rmid_tie_latency: got %0d expected 3", first_n); end
   endtask

   // Model: a request seen by an idle arbiter in cycle s occupies the memory in cycles
   // s+1..s+L, acks in cycle s+L+1, and the arbiter looks again in cycle s+L+2.
   task automatic test_random(input int k, input int ncyc);
      int            lat = lat_of(k);
      bit            inflight = 1'b0;
      int            s = 0;
      int            next_sample = 0;
      bit            g_port = 1'b0;
      bit            g_we = 1'b0;
      logic [AW-1:0] g_addr = '0;
      logic [DW-1:0] g_wdata = '0;
      bit            last_grant = 1'b1;
      bit            m_owner = 1'b0;
      logic [DW-1:0] m_if_rd = '0;
      logic [DW-1:0] m_d_rd = '0;
      bit            in_acc, in_resp;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      reset = 1'b1;
      if_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         in_acc  = inflight && c >= s + 1 && c <= s + lat;
         in_resp = inflight && c == s + lat + 1;
         e_addr  = in_acc ? g_addr : '0;
         e_wdata = in_acc ? g_wdata : '0;
         checks++; if (busy[k] !== (in_acc || in_resp)) begin errors++; $display("FAIL rnd%0d_busy c=%0d: got %b expected %b", k, c, busy[k], in_acc || in_resp); end
         checks++; if (if_ack[k] !== (in_resp && !g_port)) begin errors++; $display("FAIL rnd%0d_if_ack c=%0d: got %b expected %b", k, c, if_ack[k], in_resp && !g_port); end
         checks++; if (d_ack[k] !== (in_resp && g_port)) begin errors++; $display("FAIL rnd%0d_d_ack c=%0d: got %b expected %b", k, c, d_ack[k], in_resp && g_port); end
         checks++; if (mem_we[k] !== (inflight && c == s + 1 && g_we)) begin errors++; $display("FAIL rnd%0d_mem_we c=%0d: got %b expected %b", k, c, mem_we[k], inflight && c == s + 1 && g_we); end
         checks++; if (mem_addr[k] !== e_addr) begin errors++; $display("FAIL rnd%0d_mem_addr c=%0d: got %0h expected %0h", k, c, mem_addr[k], e_addr); end
         checks++; if (mem_wdata[k] !== e_wdata) begin errors++; $display("FAIL rnd%0d_mem_wdata c=%0d: got %0h expected %0h", k, c, mem_wdata[k], e_wdata); end
         checks++; if (owner[k] !== m_owner) begin errors++; $display("FAIL rnd%0d_owner c=%0d: got %b expected %b", k, c, owner[k], m_owner); end
         checks++; if (if_rdata[k] !== m_if_rd) begin errors++; $display("FAIL rnd%0d_if_rdata c=%0d: got %0h expected %0h", k, c, if_rdata[k], m_if_rd); end
         checks++; if (d_rdata[k] !== m_d_rd) begin errors++; $display("FAIL rnd%0d_d_rdata c=%0d: got %0h expected %0h", k, c, d_rdata[k], m_d_rd); end

         mem_rdata[k] = {$urandom, $urandom};
         if (inflight && c == s + lat && !g_we) begin
            if (g_port) m_d_rd = mem_rdata[k];
            else        m_if_rd = mem_rdata[k];
         end
         if (in_resp) begin inflight = 1'b0; next_sample = c + 1; end

         if (in_resp && !g_port) begin
            if_req[k] = 1'($urandom_range(1)); if_addr[k] = {$urandom, $urandom};
         end else if (!if_req[k] && !(inflight && !g_port)) begin
            if ($urandom_range(2) == 0) begin if_req[k] = 1'b1; if_addr[k] = {$urandom, $urandom}; end
         end else if (if_req[k] && in_acc && !g_port && $urandom_range(5) == 0) begin
            if_req[k] = 1'b0;
         end
         if (in_resp && g_port) begin
            d_req[k] = 1'($urandom_range(1)); d_we[k] = 1'($urandom_range(1));
            d_addr[k] = {$urandom, $urandom}; d_wdata[k] = {$urandom, $urandom};
         end else if (!d_req[k] && !(inflight && g_port)) begin
            if ($urandom_range(2) == 0) begin
               d_req[k] = 1'b1; d_we[k] = 1'($urandom_range(1));
               d_addr[k] = {$urandom, $urandom}; d_wdata[k] = {$urandom, $urandom};
            end
         end else if (d_req[k] && in_acc && g_port && $urandom_range(5) == 0) begin
            d_req[k] = 1'b0;
         end

         if (!inflight && c >= next_sample && (if_req[k] || d_req[k])) begin
            g_port     = (if_req[k] && d_req[k]) ? !last_grant : d_req[k];
            last_grant = g_port;
            m_owner    = g_port;
            inflight   = 1'b1;
            s          = c;
            g_we       = g_port && d_we[k];
            g_addr     = g_port ? d_addr[k] : if_addr[k];
            g_wdata    = g_port ? d_wdata[k] : '0;
         end
      end
      if_req[k] = 1'b0; d_req[k] = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
         d_addr[k] = '0; d_wdata[k] = '0; mem_rdata[k] = '0;
      end
      test_reset();
      test_fetch();
      test_load();
      test_store();
      test_latency();
      test_tie();
      test_reset_mid();
      test_random(0, 300);
      test_random(1, 300);
      test_random(2, 500);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "simulation time limit");
   end

endmodule
